// File: rtl/bs_link_port.sv
// bs_link_port: full-duplex two-wire link endpoint (frame strobe + serial data), TX FIFO, RX abort detect; BS_LINK_PARITY_EN adds even parity.
// Latency: push edge to sig_out high is 2 clk; tx_ready falls while the TX FIFO is full, and pushes are ignored while it is low.

module bs_link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             push;
  logic             pop;

  // push_rdy is a register, so a pop in this cycle cannot admit a push in the same cycle
  assign push    = push_vld & push_rdy;
  assign pop     = pop_rdy & pop_vld;
  assign pop_vld = (cnt != '0);
  assign pop_dat = mem[rd_ptr];
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      push_rdy <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt      <= cnt_nxt;
      push_rdy <= (cnt_nxt < CW'(DEPTH));
    end
  end
endmodule

module bs_link_port #(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 100,
  parameter int TX_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_busy,
  output logic             sig_out,
  output logic             bs_out,
  input  logic             sig_in,
  input  logic             bs_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err
);
`ifdef BS_LINK_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int BW = $clog2(F + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

  logic             fifo_vld;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_dat;
  logic [F-1:0]     tx_load;

  tx_state_t        tx_state;
  tx_state_t        tx_state_nxt;
  logic [CW-1:0]    tx_cyc;
  logic [CW-1:0]    tx_cyc_nxt;
  logic [BW-1:0]    tx_bit;
  logic [BW-1:0]    tx_bit_nxt;
  logic [F-1:0]     tx_sh;
  logic [F-1:0]     tx_sh_nxt;

  bs_link_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .clr_n    (clr_n),
    .push_vld (tx_valid),
    .push_rdy (tx_ready),
    .push_dat (tx_data),
    .pop_vld  (fifo_vld),
    .pop_rdy  (fifo_pop),
    .pop_dat  (fifo_dat)
  );

`ifdef BS_LINK_PARITY_EN
  assign tx_load = {^fifo_dat, fifo_dat};
`else
  assign tx_load = fifo_dat;
`endif

  assign tx_busy = fifo_vld | (tx_state != TX_IDLE);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cyc_nxt   = tx_cyc;
    tx_bit_nxt   = tx_bit;
    tx_sh_nxt    = tx_sh;
    fifo_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (fifo_vld) begin
          fifo_pop     = 1'b1;
          tx_sh_nxt    = tx_load;
          tx_cyc_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_cyc == CW'(BIT_CYCLES - 1)) begin
          tx_cyc_nxt = '0;
          tx_sh_nxt  = tx_sh >> 1;
          if (tx_bit == BW'(F - 1)) tx_state_nxt = TX_GAP;
          else                      tx_bit_nxt   = tx_bit + BW'(1);
        end else begin
          tx_cyc_nxt = tx_cyc + CW'(1);
        end
      end
      TX_GAP: begin
        // one cycle short: the IDLE pop cycle completes the low period on the wire
        if (tx_cyc == CW'(BIT_CYCLES - 2)) begin
          tx_cyc_nxt   = '0;
          tx_state_nxt = TX_IDLE;
        end else begin
          tx_cyc_nxt = tx_cyc + CW'(1);
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tx_state <= TX_IDLE;
      tx_cyc   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      sig_out  <= 1'b0;
      bs_out   <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cyc   <= tx_cyc_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_sh    <= tx_sh_nxt;
      sig_out  <= (tx_state == TX_SEND);
      bs_out   <= (tx_state == TX_SEND) & tx_sh[0];
    end
  end

  logic          sig_s1;
  logic          sig_s2;
  logic          sig_d;
  logic          bs_s1;
  logic          bs_s2;
  rx_state_t     rx_state;
  rx_state_t     rx_state_nxt;
  logic [CW-1:0] rx_cyc;
  logic [CW-1:0] rx_cyc_nxt;
  logic [BW-1:0] rx_bit;
  logic [BW-1:0] rx_bit_nxt;
  logic [F-1:0]  rx_sh;
  logic [F-1:0]  rx_sh_nxt;
  logic          done_q;
  logic          done_nxt;
  logic          abort_q;
  logic          abort_nxt;
  logic          par_bad;

`ifdef BS_LINK_PARITY_EN
  assign par_bad = ^rx_sh;
`else
  assign par_bad = 1'b0;
`endif

  // rx_cyc counts down to each sample point: half a bit first, then whole bits
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cyc_nxt   = rx_cyc;
    rx_bit_nxt   = rx_bit;
    rx_sh_nxt    = rx_sh;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (sig_s2 && !sig_d) begin
          rx_state_nxt = RX_RECV;
          rx_cyc_nxt   = CW'(BIT_CYCLES / 2 - 1);
          rx_bit_nxt   = '0;
        end
      end
      RX_RECV: begin
        if (!sig_s2) begin
          abort_nxt    = 1'b1;
          rx_state_nxt = RX_IDLE;
        end else if (rx_cyc == '0) begin
          rx_sh_nxt  = (rx_sh >> 1) | (F'(bs_s2) << (F - 1));
          rx_cyc_nxt = CW'(BIT_CYCLES - 1);
          if (rx_bit == BW'(F - 1)) begin
            done_nxt     = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_bit_nxt = rx_bit + BW'(1);
          end
        end else begin
          rx_cyc_nxt = rx_cyc - CW'(1);
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sig_s1   <= 1'b0;
      sig_s2   <= 1'b0;
      sig_d    <= 1'b0;
      bs_s1    <= 1'b0;
      bs_s2    <= 1'b0;
      rx_state <= RX_IDLE;
      rx_cyc   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      sig_s1   <= sig_in;
      sig_s2   <= sig_s1;
      sig_d    <= sig_s2;
      bs_s1    <= bs_in;
      bs_s2    <= bs_s1;
      rx_state <= rx_state_nxt;
      rx_cyc   <= rx_cyc_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_sh    <= rx_sh_nxt;
      done_q   <= done_nxt;
      abort_q  <= abort_nxt;
      rx_valid <= done_q;
      rx_err   <= abort_q | (done_q & par_bad);
      if (done_q) rx_data <= rx_sh[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_bs_link_port.sv
// Bench for bs_link_port: loopback and directly driven frames checked against a word queue and wire-timing rules.
module tb_bs_link_port;
  localparam int W  = 16;
  localparam int BC = 4;
  localparam int D  = 4;
`ifdef BS_LINK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int F      = W + PAR;
  localparam int RX_LAT = 3 + (F - 1) * BC + BC / 2 + 1;

  logic         clk = 1'b0;
  logic         clr_n = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic         tx_busy;
  logic         sig_out;
  logic         bs_out;
  logic         sig_in;
  logic         bs_in;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_err;

  logic lb = 1'b1;
  logic drv_sig = 1'b0;
  logic drv_bs = 1'b0;
  assign sig_in = lb ? sig_out : drv_sig;
  assign bs_in  = lb ? bs_out  : drv_bs;

  bs_link_port #(.WIDTH(W), .BIT_CYCLES(BC), .TX_DEPTH(D)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .sig_out  (sig_out),
    .bs_out   (bs_out),
    .sig_in   (sig_in),
    .bs_in    (bs_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [W-1:0] expq[$];
  logic [W-1:0] last_rx = '0;
  int n_vld = 0;
  int n_errp = 0;
  int n_both = 0;
  int hi_len = 0;
  int lo_len = 0;
  bit have_fall = 0;
  bit prev_sig = 0;
  int gaps[$];
  int rise_cyc = 0;
  int vld_cyc = 0;

  // wire-level monitor: frame length, inter-frame gap, and in-order word delivery
  always @(negedge clk) begin
    if (!clr_n) begin
      hi_len = 0; lo_len = 0; have_fall = 0; prev_sig = 0;
    end else begin
      if (sig_out) begin
        if (!prev_sig) begin
          rise_cyc = cyc;
          if (have_fall) gaps.push_back(lo_len);
        end
        hi_len++;
      end else begin
        if (prev_sig) begin
          chk("sig_hi_len", hi_len, F * BC);
          have_fall = 1; lo_len = 0; hi_len = 0;
        end
        lo_len++;
      end
      prev_sig = sig_out;
      if (rx_valid) begin
        n_vld++;
        vld_cyc = cyc;
        chk("rx_expected_word", 32'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          last_rx = expq.pop_front();
          chk("rx_data", 32'(rx_data), 32'(last_rx));
        end
      end
      if (rx_err) n_errp++;
      if (rx_err && rx_valid) n_both++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] w, output int t0);
    int t = 0;
    while (!tx_ready && t < 1000) begin tick(1); t++; end
    chk("push_ready", 32'(tx_ready), 1);
    tx_data = w; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    expq.push_back(w);
    t0 = cyc;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((expq.size() != 0 || tx_busy || sig_out) && t < 5000) begin tick(1); t++; end
    chk("drain", expq.size(), 0);
    tick(3 * BC);
  endtask

  task automatic drive_frame(input logic [W-1:0] w, input logic pbit);
    lb = 1'b0; drv_sig = 1'b1;
    for (int k = 0; k < F; k++) begin
      drv_bs = (k < W) ? w[k] : pbit;
      tick(BC);
    end
    drv_sig = 1'b0; drv_bs = 1'b0;
    tick(3 * BC);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t, v0, e0, b0, occ;
    logic [W-1:0] w;
    logic [W-1:0] wv[5];

    #2 clr_n = 1'b0;
    tick(3);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_tx_busy", 32'(tx_busy), 0);
    chk("rst_sig_out", 32'(sig_out), 0);
    chk("rst_bs_out", 32'(bs_out), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_err", 32'(rx_err), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    clr_n = 1'b1;
    tick(1);
    chk("ready_after_rst", 32'(tx_ready), 1);

    // single loopback frame with latency checks
    w = 16'hA5C3;
    v0 = n_vld; e0 = n_errp;
    push(w, t0);
    chk("sig_t0", 32'(sig_out), 0);
    tick(1);
    chk("sig_t0p1", 32'(sig_out), 0);
    tick(1);
    chk("sig_t0p2", 32'(sig_out), 1);
    chk("bit0_t0p2", 32'(bs_out), 32'(w[0]));
    wait_idle();
    chk("lb_rx_data", 32'(rx_data), 32'(w));
    chk("lb_vld_count", n_vld - v0, 1);
    chk("lb_err_count", n_errp - e0, 0);
    chk("tx_latency", rise_cyc - t0, 2);
    chk("rx_latency", vld_cyc - rise_cyc, RX_LAT);

    // fill the FIFO while a frame is on the wire
    v0 = n_vld;
    push(W'($urandom), t0);
    t = 0;
    while (!sig_out && t < 20) begin tick(1); t++; end
    chk("busy_frame_start", 32'(sig_out), 1);
    tick(1);
    gaps.delete();
    occ = 0;
    for (int i = 0; i < 5; i++) begin
      wv[i] = W'($urandom);
      tx_data = wv[i]; tx_valid = 1'b1;
      chk("ready_before_push", 32'(tx_ready), 32'(occ < D));
      if (occ < D) begin expq.push_back(wv[i]); occ++; end
      tick(1);
      chk("ready_after_push", 32'(tx_ready), 32'(occ < D));
    end
    tick(6);
    chk("ready_held_full", 32'(tx_ready), 32'(occ < D));
    tx_valid = 1'b0;
    wait_idle();
    chk("b2b_vld_count", n_vld - v0, 5);
    chk("b2b_gap_count", gaps.size(), 4);
    foreach (gaps[i]) chk("b2b_gap_len", gaps[i], BC);

    // random words with random spacing
    v0 = n_vld; e0 = n_errp;
    for (int i = 0; i < 10; i++) begin
      push(W'($urandom), t0);
      tick(int'($urandom_range(0, 90)));
    end
    wait_idle();
    chk("rand_vld_count", n_vld - v0, 10);
    chk("rand_err_count", n_errp - e0, 0);

    // aborted frame: sig high for 5 bit periods only
    v0 = n_vld; e0 = n_errp;
    lb = 1'b0; drv_sig = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drv_bs = 1'($urandom);
      tick(BC);
    end
    drv_sig = 1'b0; drv_bs = 1'b0;
    tick(4 * BC);
    chk("abort_err_count", n_errp - e0, 1);
    chk("abort_vld_count", n_vld - v0, 0);
    chk("abort_rx_data", 32'(rx_data), 32'(last_rx));

    // directly driven good frame
    v0 = n_vld; e0 = n_errp;
    w = W'($urandom);
    expq.push_back(w);
    drive_frame(w, ^w);
    chk("drv_vld_count", n_vld - v0, 1);
    chk("drv_err_count", n_errp - e0, 0);
    chk("drv_rx_data", 32'(rx_data), 32'(w));

    // 0x0001 with parity bit 0: a parity error when parity is enabled
    v0 = n_vld; e0 = n_errp; b0 = n_both;
    expq.push_back(16'h0001);
    drive_frame(16'h0001, 1'b0);
    lb = 1'b1;
    chk("par_rx_data", 32'(rx_data), 1);
    chk("par_vld_count", n_vld - v0, 1);
    chk("par_err_count", n_errp - e0, PAR);
    chk("par_same_cycle", n_both - b0, PAR);

    // reset in the middle of a frame
    push(W'($urandom), t0);
    tick(30);
    chk("pre_rst_sig", 32'(sig_out), 1);
    clr_n = 1'b0;
    #1;
    chk("midrst_sig_out", 32'(sig_out), 0);
    chk("midrst_bs_out", 32'(bs_out), 0);
    chk("midrst_tx_busy", 32'(tx_busy), 0);
    chk("midrst_tx_ready", 32'(tx_ready), 0);
    expq.delete();
    last_rx = '0;
    tick(2);
    clr_n = 1'b1;
    tick(1);
    chk("postrst_rx_data", 32'(rx_data), 0);
    chk("postrst_ready", 32'(tx_ready), 1);
    v0 = n_vld; e0 = n_errp;
    w = W'($urandom);
    push(w, t0);
    wait_idle();
    chk("postrst_vld_count", n_vld - v0, 1);
    chk("postrst_err_count", n_errp - e0, 0);
    chk("postrst_word", 32'(rx_data), 32'(w));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
